// File: rtl/median3x3_scanner.sv
// ---------------------------------------------------------------------------
// median3x3_scanner
//
// Scans a 1-bit image held in flatMem in raster order. For every pixel it
// reads the 3x3 neighbourhood through flatMem's registered read port and
// emits the binary median (majority of 9) with a valid/ready handshake.
// Neighbours outside the image count as 0.
//
// Per pixel: 9 FETCH cycles (one address per neighbour), 1 WAIT cycle to
// collect the last read, then OUT until the result is accepted.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   start        one-cycle pulse, starts a frame scan (only honoured in IDLE)
//   xAddressOut  x address to flatMem read port
//   yAddressOut  y address to flatMem read port
//   memDataIn    flatMem read data, valid one cycle after the address
//   outPixel     filtered pixel value
//   outX, outY   coordinates of outPixel
//   outValid     outPixel/outX/outY valid
//   outReady     downstream accepts when outValid && outReady
//   busy         high while a frame scan is in progress
//   done         one-cycle pulse after the last pixel is accepted
// ---------------------------------------------------------------------------
module median3x3_scanner #(
    parameter int IMWIDTH  = 240,
    parameter int IMHEIGHT = 180,
    parameter int ADDRW    = 8,
    parameter int THRESH   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [ADDRW-1:0] xAddressOut,
    output logic [ADDRW-1:0] yAddressOut,
    input  logic             memDataIn,
    output logic             outPixel,
    output logic [ADDRW-1:0] outX,
    output logic [ADDRW-1:0] outY,
    output logic             outValid,
    input  logic             outReady,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_OUT   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDRW+1:0] W_LIM    = (ADDRW+2)'(IMWIDTH);
    localparam logic [ADDRW+1:0] H_LIM    = (ADDRW+2)'(IMHEIGHT);
    localparam logic [ADDRW-1:0] X_LAST   = ADDRW'(IMWIDTH - 1);
    localparam logic [ADDRW-1:0] Y_LAST   = ADDRW'(IMHEIGHT - 1);
    localparam logic [3:0]       THRESH_L = 4'(THRESH);

    logic [2:0]       state_r;
    logic [ADDRW-1:0] cx_r;
    logic [ADDRW-1:0] cy_r;
    logic [3:0]       k_r;
    logic [3:0]       ones_r;
    logic             pad_r;     // pad flag of the address currently on the bus
    logic             pad_d_r;   // pad flag aligned with memDataIn

    logic             last_px_s;
    logic [ADDRW-1:0] nxt_cx_s;
    logic [ADDRW-1:0] nxt_cy_s;
    logic [ADDRW-1:0] fx_s;
    logic [ADDRW-1:0] fy_s;
    logic [3:0]       fk_s;
    logic [ADDRW:0]   xn_s;
    logic [ADDRW:0]   yn_s;
    logic             pad_s;
    logic             sample_s;
    logic [3:0]       ones_next_s;

    // Column offset index (0..2 meaning -1..+1) of neighbour k.
    function automatic logic [1:0] k_col(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: k_col = 2'd0;
            4'd1, 4'd4, 4'd7: k_col = 2'd1;
            default:          k_col = 2'd2;
        endcase
    endfunction

    // Row offset index (0..2 meaning -1..+1) of neighbour k.
    function automatic logic [1:0] k_row(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: k_row = 2'd0;
            4'd3, 4'd4, 4'd5: k_row = 2'd1;
            default:          k_row = 2'd2;
        endcase
    endfunction

    // Returns {pad, coordinate}: c + off - 1 clamped into 0..lim-1; pad set
    // when clamping was needed. Works on c + off to stay unsigned.
    function automatic logic [ADDRW:0] nbr_coord(input logic [ADDRW-1:0] c,
                                                 input logic [1:0]       off,
                                                 input logic [ADDRW+1:0] lim);
        logic [ADDRW+1:0] s;
        s = {2'b00, c} + {{ADDRW{1'b0}}, off};
        if (s == {(ADDRW+2){1'b0}}) begin
            nbr_coord = {1'b1, {ADDRW{1'b0}}};
        end else if (s > lim) begin
            nbr_coord = {1'b1, ADDRW'(lim - (ADDRW+2)'(1))};
        end else begin
            nbr_coord = {1'b0, ADDRW'(s - (ADDRW+2)'(1))};
        end
    endfunction

    // Raster advance: next pixel coordinates and last-pixel detection.
    always_comb begin
        last_px_s = (cx_r == X_LAST) && (cy_r == Y_LAST);
        if (cx_r == X_LAST) begin
            nxt_cx_s = {ADDRW{1'b0}};
            nxt_cy_s = cy_r + ADDRW'(1);
        end else begin
            nxt_cx_s = cx_r + ADDRW'(1);
            nxt_cy_s = cy_r;
        end
    end

    // Selects which (pixel, k) the next address load refers to: first
    // neighbour of (0,0) on start, first neighbour of the next pixel on
    // accept, otherwise neighbour k+1 of the current pixel.
    always_comb begin
        fx_s = cx_r;
        fy_s = cy_r;
        fk_s = k_r + 4'd1;
        if (state_r == ST_IDLE) begin
            fx_s = {ADDRW{1'b0}};
            fy_s = {ADDRW{1'b0}};
            fk_s = 4'd0;
        end else if (state_r == ST_OUT) begin
            fx_s = nxt_cx_s;
            fy_s = nxt_cy_s;
            fk_s = 4'd0;
        end else begin
            fk_s = k_r + 4'd1;
        end
        xn_s  = nbr_coord(fx_s, k_col(fk_s), W_LIM);
        yn_s  = nbr_coord(fy_s, k_row(fk_s), H_LIM);
        pad_s = xn_s[ADDRW] | yn_s[ADDRW];
    end

    // Read data returns one cycle after issue: FETCH k>=1 sees sample k-1,
    // WAIT sees sample 8. Padded neighbours contribute 0.
    always_comb begin
        sample_s = 1'b0;
        if (((state_r == ST_FETCH) && (k_r != 4'd0)) || (state_r == ST_WAIT)) begin
            sample_s = ~pad_d_r & memDataIn;
        end else begin
            sample_s = 1'b0;
        end
        ones_next_s = ones_r + {3'b000, sample_s};
    end

    // Main scan FSM, counters, address and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cx_r        <= {ADDRW{1'b0}};
            cy_r        <= {ADDRW{1'b0}};
            k_r         <= 4'd0;
            ones_r      <= 4'd0;
            pad_r       <= 1'b0;
            pad_d_r     <= 1'b0;
            xAddressOut <= {ADDRW{1'b0}};
            yAddressOut <= {ADDRW{1'b0}};
            outPixel    <= 1'b0;
            outX        <= {ADDRW{1'b0}};
            outY        <= {ADDRW{1'b0}};
            outValid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            pad_d_r <= pad_r;
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r     <= ST_FETCH;
                        cx_r        <= {ADDRW{1'b0}};
                        cy_r        <= {ADDRW{1'b0}};
                        k_r         <= 4'd0;
                        ones_r      <= 4'd0;
                        busy        <= 1'b1;
                        xAddressOut <= xn_s[ADDRW-1:0];
                        yAddressOut <= yn_s[ADDRW-1:0];
                        pad_r       <= pad_s;
                    end
                end
                ST_FETCH: begin
                    ones_r <= ones_next_s;
                    if (k_r == 4'd8) begin
                        state_r <= ST_WAIT;
                    end else begin
                        k_r         <= k_r + 4'd1;
                        xAddressOut <= xn_s[ADDRW-1:0];
                        yAddressOut <= yn_s[ADDRW-1:0];
                        pad_r       <= pad_s;
                    end
                end
                ST_WAIT: begin
                    ones_r   <= ones_next_s;
                    state_r  <= ST_OUT;
                    outValid <= 1'b1;
                    outPixel <= (ones_next_s >= THRESH_L);
                    outX     <= cx_r;
                    outY     <= cy_r;
                end
                ST_OUT: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        if (last_px_s) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r     <= ST_FETCH;
                            cx_r        <= nxt_cx_s;
                            cy_r        <= nxt_cy_s;
                            k_r         <= 4'd0;
                            ones_r      <= 4'd0;
                            xAddressOut <= xn_s[ADDRW-1:0];
                            yAddressOut <= yn_s[ADDRW-1:0];
                            pad_r       <= pad_s;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    outValid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
